// File: rtl/bvh_fetch_arbiter_if.sv
// Handshake bundle between the BVH traversal requesters, the shared
// node/leaf memory read port and the fetch arbiter.
interface bvh_fetch_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_index;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          mem_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic                          idle;

  modport master (
    output req_valid, req_index, mem_data,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_addr, idle
  );

  modport slave (
    input  req_valid, req_index, mem_data,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_addr, idle
  );
endinterface

// File: rtl/bvh_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency BVH memory read port between
// traversal requesters; a tag pipeline routes each returning word back.
module bvh_fetch_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 256,
  parameter int READ_LATENCY = 2
) (
  input logic               clk,
  input logic               resetn,
  bvh_fetch_arbiter_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [ID_W-1:0] id_t;

  id_t                     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      busy_q, busy_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  id_t                     tag_id_q [READ_LATENCY];
  id_t                     tag_id_d [READ_LATENCY];

  logic [NUM_REQ-1:0] elig;
  logic               gnt_vld;
  id_t                gnt_id;
  logic               rsp_vld;
  id_t                rsp_id;

  // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off <= NUM_REQ.
  function automatic id_t wrap_add(input id_t base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= unsigned'(NUM_REQ)) s = s - unsigned'(NUM_REQ);
    return id_t'(s);
  endfunction

  always_comb begin
    elig    = bus.req_valid & ~busy_q;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      if (!gnt_vld && elig[wrap_add(rr_ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_id  = wrap_add(rr_ptr_q, k);
      end
    end
    if (!resetn) gnt_vld = 1'b0;
  end

  assign rsp_vld = resetn && tag_vld_q[READ_LATENCY-1];
  assign rsp_id  = tag_id_q[READ_LATENCY-1];

  // A response never targets the requester being granted (it is still busy),
  // so the clear and the set touch different bits.
  always_comb begin
    busy_d = busy_q;
    if (rsp_vld) busy_d[rsp_id] = 1'b0;
    if (gnt_vld) busy_d[gnt_id] = 1'b1;

    rr_ptr_d = gnt_vld ? wrap_add(gnt_id, 1) : rr_ptr_q;

    tag_vld_d = '0;
    for (int unsigned s = 0; s < unsigned'(READ_LATENCY); s++) tag_id_d[s] = '0;
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_id;
    for (int unsigned s = 1; s < unsigned'(READ_LATENCY); s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < unsigned'(READ_LATENCY); s++) tag_id_q[s] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      tag_vld_q <= tag_vld_d;
      for (int unsigned s = 0; s < unsigned'(READ_LATENCY); s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_vld) bus.req_ready[gnt_id] = 1'b1;
    bus.mem_en   = gnt_vld;
    bus.mem_addr = gnt_vld ? bus.req_index[gnt_id*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (rsp_vld) begin
      bus.rsp_valid[rsp_id] = 1'b1;
      bus.rsp_data          = bus.mem_data;
    end
  end

  assign bus.idle = !resetn || ((busy_q == '0) && (bus.req_valid == '0));

endmodule

// File: tb/tb_bvh_fetch_arbiter.sv
// Bench for bvh_fetch_arbiter: directed vector table, round-robin fairness
// run against a small reference model, and a 3-requester wrap sequence.
`timescale 1ns/1ps
module tb_bvh_fetch_arbiter;
  localparam int AW = 10;
  localparam int DW = 256;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn2, resetn3;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  bvh_fetch_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2();
  bvh_fetch_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3();

  bvh_fetch_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL))
    dut2 (.clk(clk), .resetn(resetn2), .bus(bus2));
  bvh_fetch_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL))
    dut3 (.clk(clk), .resetn(resetn3), .bus(bus3));

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'hA500_0000 | (32'(a) << 8) | 32'(i);
    return w;
  endfunction

  // Fixed-latency memories; they keep returning data across DUT resets.
  logic [DW-1:0] pipe2 [RL];
  logic [DW-1:0] pipe3 [RL];
  always @(posedge clk) begin
    pipe2[0] <= bus2.mem_en ? word(bus2.mem_addr) : '0;
    pipe3[0] <= bus3.mem_en ? word(bus3.mem_addr) : '0;
    for (int s = 1; s < RL; s++) begin
      pipe2[s] <= pipe2[s-1];
      pipe3[s] <= pipe3[s-1];
    end
  end
  assign bus2.mem_data = pipe2[RL-1];
  assign bus3.mem_data = pipe3[RL-1];

  typedef struct {
    int unsigned   due;
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_rsp_t;
  exp_rsp_t sbq[$];

  typedef struct {
    logic          rstn;
    logic [1:0]    rv;
    logic [AW-1:0] i0;
    logic [AW-1:0] i1;
    logic [1:0]    rdy;
    logic [AW-1:0] addr;
    logic          idle;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [DW-1:0] data);
    exp_rsp_t e;
    e.due  = cyc + RL;
    e.id   = id;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic check_rsp2();
    logic [1:0]    ev;
    logic [DW-1:0] ed;
    ev = '0;
    ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ev = sbq[0].id;
      ed = sbq[0].data;
      void'(sbq.pop_front());
    end
    chk("rsp_valid", DW'(bus2.rsp_valid), DW'(ev));
    chk("rsp_data", bus2.rsp_data, ed);
  endtask

  logic [1:0]    rv, e, g, prev;
  logic [AW-1:0] i0, i1;
  logic          m_rr;
  int            m_cnt [2];
  int            viol, g0, g1;
  logic [2:0]    exp_rdy3 [4];
  logic [AW-1:0] exp_addr3 [4];
  logic [2:0]    exp_rsp3 [4];
  logic [DW-1:0] ed3;

  initial begin
    //         rstn  rv     i0      i1      rdy    addr    idle
    tbl[0]  = '{1'b1, 2'b01, 10'h005, 10'h000, 2'b01, 10'h005, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b1};
    tbl[2]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b1};
    tbl[3]  = '{1'b1, 2'b11, 10'h003, 10'h007, 2'b01, 10'h003, 1'b0};
    tbl[4]  = '{1'b1, 2'b10, 10'h003, 10'h007, 2'b10, 10'h007, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b1};
    tbl[8]  = '{1'b1, 2'b01, 10'h012, 10'h000, 2'b01, 10'h012, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 10'h012, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[10] = '{1'b1, 2'b01, 10'h012, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[11] = '{1'b1, 2'b01, 10'h012, 10'h000, 2'b01, 10'h012, 1'b0};
    tbl[12] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[13] = '{1'b1, 2'b10, 10'h000, 10'h3FF, 2'b10, 10'h3FF, 1'b0};
    tbl[14] = '{1'b1, 2'b01, 10'h044, 10'h3FF, 2'b01, 10'h044, 1'b0};
    tbl[15] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[16] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[17] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b1};
    tbl[18] = '{1'b1, 2'b11, 10'h0AA, 10'h100, 2'b10, 10'h100, 1'b0};
    tbl[19] = '{1'b1, 2'b01, 10'h0BB, 10'h100, 2'b01, 10'h0BB, 1'b0};
    tbl[20] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[21] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b0};
    tbl[22] = '{1'b1, 2'b00, 10'h000, 10'h000, 2'b00, 10'h000, 1'b1};

    resetn2 = 1'b0;
    resetn3 = 1'b0;
    bus2.req_valid = 2'b11;
    bus2.req_index = {10'h007, 10'h003};
    bus3.req_valid = 3'b111;
    bus3.req_index = {10'h030, 10'h020, 10'h010};

    // Outputs must stay quiet during reset even with requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", DW'(bus2.req_ready), DW'(2'b00));
    chk("reset_mem_en", DW'(bus2.mem_en), DW'(1'b0));
    chk("reset_mem_addr", DW'(bus2.mem_addr), DW'(10'h000));
    chk("reset_idle", DW'(bus2.idle), DW'(1'b1));
    chk("reset_rsp_valid", DW'(bus2.rsp_valid), DW'(2'b00));
    chk("reset3_ready", DW'(bus3.req_ready), DW'(3'b000));

    for (int k = 0; k < 23; k++) begin
      @(posedge clk); #1;
      resetn2        = tbl[k].rstn;
      bus2.req_valid = tbl[k].rv;
      bus2.req_index = {tbl[k].i1, tbl[k].i0};
      if (!tbl[k].rstn) sbq.delete();
      else if (tbl[k].rdy != 2'b00) push_exp(tbl[k].rdy, word(tbl[k].addr));
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", k), DW'(bus2.req_ready), DW'(tbl[k].rdy));
      chk($sformatf("v%0d_mem_en", k), DW'(bus2.mem_en), DW'(tbl[k].rdy != 2'b00));
      chk($sformatf("v%0d_mem_addr", k), DW'(bus2.mem_addr), DW'(tbl[k].addr));
      chk($sformatf("v%0d_idle", k), DW'(bus2.idle), DW'(tbl[k].idle));
      check_rsp2();
    end

    // Fairness: both requesters always asking; pointer starts at 1 here.
    m_rr = 1'b1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    prev = 2'b00;
    viol = 0;
    g0 = 0;
    g1 = 0;
    for (int k = 0; k < 44; k++) begin
      @(posedge clk); #1;
      rv = (k < 40) ? 2'b11 : 2'b00;
      i0 = AW'($urandom);
      i1 = AW'($urandom);
      bus2.req_valid = rv;
      bus2.req_index = {i1, i0};
      e = rv & {m_cnt[1] == 0, m_cnt[0] == 0};
      g = (e == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : e;
      if (g != 2'b00) push_exp(g, word(g[1] ? i1 : i0));
      @(negedge clk);
      chk("rr_req_ready", DW'(bus2.req_ready), DW'(g));
      chk("rr_mem_addr", DW'(bus2.mem_addr), DW'((g == 2'b00) ? AW'(0) : (g[1] ? i1 : i0)));
      check_rsp2();
      if (bus2.req_ready != 2'b00 && bus2.req_ready == prev && (e & ~bus2.req_ready) != 2'b00)
        viol++;
      prev = bus2.req_ready;
      g0 += int'(bus2.req_ready[0]);
      g1 += int'(bus2.req_ready[1]);
      for (int i = 0; i < 2; i++) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        if (g[i]) m_cnt[i] = RL;
      end
      if (g != 2'b00) m_rr = g[0];
    end
    chk("rr_consecutive_viol", DW'(viol), DW'(0));
    chk("rr_balance", DW'((g0 > g1 ? g0 - g1 : g1 - g0) <= 1), DW'(1'b1));
    chk("sb_drained", DW'(sbq.size()), DW'(0));

    // Three requesters: grant order 0,1,2 then the pointer wraps to 0.
    exp_rdy3  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr3 = '{10'h010, 10'h020, 10'h030, 10'h010};
    exp_rsp3  = '{3'b000, 3'b000, 3'b001, 3'b010};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      resetn3 = 1'b1;
      @(negedge clk);
      ed3 = (k == 2) ? word(10'h010) : (k == 3) ? word(10'h020) : '0;
      chk($sformatf("w%0d_req_ready", k), DW'(bus3.req_ready), DW'(exp_rdy3[k]));
      chk($sformatf("w%0d_mem_addr", k), DW'(bus3.mem_addr), DW'(exp_addr3[k]));
      chk($sformatf("w%0d_rsp_valid", k), DW'(bus3.rsp_valid), DW'(exp_rsp3[k]));
      chk($sformatf("w%0d_rsp_data", k), bus3.rsp_data, ed3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
